// File: rtl/nios2sys_oci_pkg.sv
// rtl/nios2sys_oci_pkg.sv - shared types and jdo field positions for the OCI debug memory block
package nios2sys_oci_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int OCI_DATA_W = 32;

    localparam int JDO_W         = 38;
    localparam int JDO_LOAD_ADDR = 35;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_READ      = 25;
    localparam int JDO_CLR_ERR   = 24;
    localparam int JDO_DATA_MSB  = 34;
    localparam int JDO_DATA_LSB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_JCAP = 2'd2,
        ST_JWR  = 2'd3
    } oci_state_e;

endpackage

// File: rtl/nios2sys_oci_ram.sv
// rtl/nios2sys_oci_ram.sv - single-port byte-enabled debug RAM with registered read data
module nios2sys_oci_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     q_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] q_q;

    // Contents are deliberately not reset; only the read register follows the address.
    always_ff @(posedge clk_i) begin
        q_q <= mem_q[addr_i];
        if (we_i) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/nios2sys_cpu_oci_mem_access.sv
// rtl/nios2sys_cpu_oci_mem_access.sv - JTAG/CPU arbitration onto the shared OCI debug RAM
// Optional CPU write path: NIOS2SYS_OCI_CPU_WRITE_EN
module nios2sys_cpu_oci_mem_access
    import nios2sys_oci_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_waitrequest,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);

`ifdef NIOS2SYS_OCI_CPU_WRITE_EN
    localparam bit CPU_WR_EN = 1'b1;
`else
    localparam bit CPU_WR_EN = 1'b0;
`endif

    oci_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   mona_q, mona_d;
    logic [DATA_W-1:0]   mond_q, mond_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;
    logic                rd_valid_q, rd_valid_d;

    logic                strobe_any;
    logic                jtag_busy;
    logic                cpu_rd;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_q;
    logic                unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_LOAD_ADDR+1], jdo[JDO_DATA_LSB-1:0]};

    assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jtag_busy  = (state_q != ST_IDLE) || strobe_any;
    assign cpu_rd     = cpu_read && !cpu_write;

    always_comb begin
        state_d = state_q;
        mona_d  = mona_q;
        mond_d  = mond_q;
        ready_d = ready_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    if (jdo[JDO_LOAD_ADDR]) mona_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_CLR_ERR])   error_d = 1'b0;
                    if (jdo[JDO_READ])      state_d = ST_JRD;
                end else if (take_no_action_ocimem_a) begin
                    mona_d  = mona_q + ADDR_W'(1);
                    state_d = ST_JRD;
                end else if (take_action_ocimem_b) begin
                    mond_d  = DATA_W'(jdo[JDO_DATA_MSB:JDO_DATA_LSB]);
                    state_d = ST_JWR;
                end
            end
            ST_JRD:  state_d = ST_JCAP;
            ST_JCAP: begin
                mond_d  = ram_q;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_JWR: begin
                mona_d  = mona_q + ADDR_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && strobe_any) error_d = 1'b1;
        // A command strobe always withdraws ready, even one that lands on a completing read.
        if (take_action_ocimem_a) ready_d = 1'b0;
    end

    // CPU owns the RAM port only while JTAG is idle; writes also gated by reset so an abort never commits.
    always_comb begin
        ram_addr  = cpu_address;
        ram_we    = 1'b0;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
        if (state_q == ST_JRD) begin
            ram_addr = mona_q;
        end else if (state_q == ST_JWR) begin
            ram_addr  = mona_q;
            ram_we    = reset_n;
            ram_be    = '1;
            ram_wdata = mond_q;
        end else if (!jtag_busy) begin
            ram_we = CPU_WR_EN && cpu_write && reset_n;
        end
    end

    assign rd_valid_d = cpu_rd && !jtag_busy && !rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mona_q     <= '0;
            mond_q     <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mona_q     <= mona_d;
            mond_q     <= mond_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    nios2sys_oci_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

    assign cpu_waitrequest = reset_n && (jtag_busy || (cpu_rd && !rd_valid_q));
    assign cpu_readdata    = rd_valid_q ? ram_q : '0;
    assign MonDReg         = mond_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

endmodule

// File: tb/tb_nios2sys_cpu_oci_mem_access.sv
// tb/tb_nios2sys_cpu_oci_mem_access.sv - directed table plus randomized model check of the OCI memory access block
module tb_nios2sys_cpu_oci_mem_access;

`ifdef NIOS2SYS_OCI_CPU_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif
    localparam int K_A = 0, K_NA = 1, K_B = 2;

    typedef struct {
        int          kind;
        bit          load;
        logic [7:0]  addr;
        bit          rd;
        bit          clr;
        logic [31:0] data;
        logic [31:0] exp_mond;
        bit          exp_ready;
        bit          exp_err;
    } jvec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        act_a, noact_a, act_b;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_mem [256];
    bit          m_known [256];
    int          cyc, free_at, rd_edge, wr_edge;
    logic [7:0]  m_addr;
    logic [31:0] m_mond, m_rdval, m_cpu_val;
    bit          m_mond_known, m_rd_known, m_ready, m_err, m_issued, m_cpu_known;

    always #5 clk = ~clk;

    nios2sys_cpu_oci_mem_access dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_no_action_ocimem_a (noact_a),
        .take_action_ocimem_b    (act_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [37:0] make_a(input bit load, input logic [7:0] addr, input bit rd, input bit clr);
        logic [37:0] j;
        j = '0;
        j[35]    = load;
        j[33:26] = addr;
        j[25]    = rd;
        j[24]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] make_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    function automatic logic [7:0] pick_addr();
        int v;
        v = int'($urandom_range(0, 11));
        return (v < 8) ? 8'(v) : 8'(v + 244);
    endfunction

    task automatic strobe(input int kind, input logic [37:0] j);
        jdo     = j;
        act_a   = (kind == K_A);
        noact_a = (kind == K_NA);
        act_b   = (kind == K_B);
        tick(1);
        act_a   = 1'b0;
        noact_a = 1'b0;
        act_b   = 1'b0;
    endtask

    task automatic jtag_op(input int kind, input logic [37:0] j);
        strobe(kind, j);
        tick(3);
    endtask

    task automatic start_read();
        m_rdval    = m_mem[m_addr];
        m_rd_known = m_known[m_addr];
        rd_edge    = cyc + 2;
        free_at    = cyc + 3;
    endtask

    // One clock of the transaction-level reference: JTAG reads hold the port for the strobe edge plus two,
    // writes for the strobe edge plus one; the CPU sees the RAM only when neither a strobe nor a JTAG op is live.
    task automatic model_cycle(output bit exp_wr);
        bit any, busy, rd_op;
        any    = act_a | noact_a | act_b;
        busy   = (cyc < free_at) || any;
        rd_op  = cpu_read && !cpu_write;
        exp_wr = busy || (rd_op && !m_issued);
        @(negedge clk);
        chk("rnd_waitrequest", 32'(cpu_waitrequest), 32'(exp_wr));
        if (rd_op && !exp_wr && m_cpu_known) chk("rnd_cpu_readdata", cpu_readdata, m_cpu_val);
        if (m_mond_known) chk("rnd_MonDReg", MonDReg, m_mond);
        chk("rnd_ready", 32'(monitor_ready), 32'(m_ready));
        chk("rnd_error", 32'(monitor_error), 32'(m_err));
        @(posedge clk);
        if (cyc == wr_edge) begin
            m_mem[m_addr]   = m_mond;
            m_known[m_addr] = 1'b1;
            m_addr++;
        end
        if (cyc == rd_edge) begin
            m_mond       = m_rdval;
            m_mond_known = m_rd_known;
            m_ready      = 1'b1;
        end
        if (rd_op && !busy && !m_issued) begin
            m_issued    = 1'b1;
            m_cpu_val   = m_mem[cpu_address];
            m_cpu_known = m_known[cpu_address];
        end else begin
            m_issued = 1'b0;
        end
        if (cpu_write && !busy && WR_EN) begin
            for (int i = 0; i < 4; i++)
                if (cpu_byteenable[i]) m_mem[cpu_address][8*i +: 8] = cpu_writedata[8*i +: 8];
            if (cpu_byteenable == 4'hF) m_known[cpu_address] = 1'b1;
        end
        if (any && cyc < free_at) begin
            m_err = 1'b1;
        end else if (act_a) begin
            if (jdo[35]) m_addr = jdo[33:26];
            if (jdo[24]) m_err = 1'b0;
            if (jdo[25]) start_read();
        end else if (noact_a) begin
            m_addr++;
            start_read();
        end else if (act_b) begin
            m_mond       = jdo[34:3];
            m_mond_known = 1'b1;
            wr_edge      = cyc + 1;
            free_at      = cyc + 2;
        end
        if (act_a) m_ready = 1'b0;
        #1;
        cyc++;
    endtask

    jvec_t tbl [18];

    initial begin
        bit          ew;
        int          op;
        logic [31:0] exp33;

        tbl[0]  = '{K_A,  1, 8'h10, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[1]  = '{K_B,  0, 8'h00, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{K_A,  1, 8'h20, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0};
        tbl[3]  = '{K_B,  0, 8'h00, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0};
        tbl[4]  = '{K_A,  1, 8'h01, 0, 0, 32'h0,        32'hCAFEF00D, 0, 0};
        tbl[5]  = '{K_B,  0, 8'h00, 0, 0, 32'h5A5A0001, 32'h5A5A0001, 0, 0};
        tbl[6]  = '{K_A,  1, 8'h05, 0, 0, 32'h0,        32'h5A5A0001, 0, 0};
        tbl[7]  = '{K_B,  0, 8'h00, 0, 0, 32'h11223344, 32'h11223344, 0, 0};
        tbl[8]  = '{K_A,  1, 8'hFE, 0, 0, 32'h0,        32'h11223344, 0, 0};
        tbl[9]  = '{K_B,  0, 8'h00, 0, 0, 32'h1,        32'h1,        0, 0};
        tbl[10] = '{K_B,  0, 8'h00, 0, 0, 32'h2,        32'h2,        0, 0};
        tbl[11] = '{K_B,  0, 8'h00, 0, 0, 32'h3,        32'h3,        0, 0};
        tbl[12] = '{K_A,  0, 8'h00, 1, 0, 32'h0,        32'h5A5A0001, 1, 0};
        tbl[13] = '{K_A,  1, 8'hFE, 1, 0, 32'h0,        32'h1,        1, 0};
        tbl[14] = '{K_NA, 0, 8'h00, 0, 0, 32'h0,        32'h2,        1, 0};
        tbl[15] = '{K_NA, 0, 8'h00, 0, 0, 32'h0,        32'h3,        1, 0};
        tbl[16] = '{K_NA, 0, 8'h00, 0, 0, 32'h0,        32'h5A5A0001, 1, 0};
        tbl[17] = '{K_A,  1, 8'h10, 1, 0, 32'h0,        32'hDEADBEEF, 1, 0};

        reset_n = 1'b0; jdo = '0; act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0; cpu_byteenable = '0;
        tick(2);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'h0);
        chk("rst_error", 32'(monitor_error), 32'h0);
        chk("rst_readdata", cpu_readdata, 32'h0);
        chk("rst_waitreq", 32'(cpu_waitrequest), 32'h0);
        reset_n = 1'b1;
        tick(1);

        for (int i = 0; i < 18; i++) begin
            jtag_op(tbl[i].kind, (tbl[i].kind == K_B) ? make_b(tbl[i].data)
                                 : make_a(tbl[i].load, tbl[i].addr, tbl[i].rd, tbl[i].clr));
            chk($sformatf("tbl%0d_MonDReg", i), MonDReg, tbl[i].exp_mond);
            chk($sformatf("tbl%0d_ready", i), 32'(monitor_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_error", i), 32'(monitor_error), 32'(tbl[i].exp_err));
        end

        // Read latency: data and ready appear on the second edge after the strobe edge.
        strobe(K_A, make_a(1, 8'h20, 1, 0));
        chk("lat_e0_ready", 32'(monitor_ready), 32'h0);
        tick(1);
        chk("lat_e1_ready", 32'(monitor_ready), 32'h0);
        chk("lat_e1_MonDReg", MonDReg, 32'hDEADBEEF);
        tick(1);
        chk("lat_e2_ready", 32'(monitor_ready), 32'h1);
        chk("lat_e2_MonDReg", MonDReg, 32'hCAFEF00D);
        tick(1);

        strobe(K_A, make_a(1, 8'h10, 1, 0));
        strobe(K_NA, make_a(0, 8'h00, 0, 0));
        tick(3);
        chk("drop_error", 32'(monitor_error), 32'h1);
        chk("drop_MonDReg", MonDReg, 32'hDEADBEEF);
        chk("drop_ready", 32'(monitor_ready), 32'h1);
        jtag_op(K_A, make_a(0, 8'h00, 0, 1));
        chk("clr_error", 32'(monitor_error), 32'h0);
        chk("clr_ready", 32'(monitor_ready), 32'h0);

        jtag_op(K_A, make_a(1, 8'h30, 0, 0));
        strobe(K_B, make_b(32'h77777777));
        cpu_read = 1'b1; cpu_address = 8'h20;
        #1 chk("prio_jwr_waitreq", 32'(cpu_waitrequest), 32'h1);
        tick(1);
        chk("prio_addr_waitreq", 32'(cpu_waitrequest), 32'h1);
        tick(1);
        chk("prio_done_waitreq", 32'(cpu_waitrequest), 32'h0);
        chk("prio_readdata", cpu_readdata, 32'hCAFEF00D);
        cpu_read = 1'b0;
        tick(1);

        cpu_write = 1'b1; cpu_address = 8'h05; cpu_writedata = 32'hAABBCCDD; cpu_byteenable = 4'b0011;
        #1 chk("cpuwr_waitreq", 32'(cpu_waitrequest), 32'h0);
        tick(1);
        cpu_write = 1'b0;
        jtag_op(K_A, make_a(1, 8'h05, 1, 0));
        exp33 = WR_EN ? 32'h1122CCDD : 32'h11223344;
        chk("cpuwr_be_result", MonDReg, exp33);

        strobe(K_A, make_a(1, 8'h10, 1, 0));
        strobe(K_B, make_b(32'h0));
        tick(3);
        chk("pre_rst_error", 32'(monitor_error), 32'h1);
        strobe(K_A, make_a(1, 8'h10, 1, 0));
        cpu_read = 1'b1; cpu_address = 8'h20;
        reset_n = 1'b0;
        #1;
        chk("jrd_rst_MonDReg", MonDReg, 32'h0);
        chk("jrd_rst_ready", 32'(monitor_ready), 32'h0);
        chk("jrd_rst_error", 32'(monitor_error), 32'h0);
        chk("jrd_rst_readdata", cpu_readdata, 32'h0);
        chk("jrd_rst_waitreq", 32'(cpu_waitrequest), 32'h0);
        tick(1);
        reset_n = 1'b1; cpu_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("post_rst%0d_ready", i), 32'(monitor_ready), 32'h0);
            chk($sformatf("post_rst%0d_MonDReg", i), MonDReg, 32'h0);
        end

        jtag_op(K_A, make_a(1, 8'h10, 0, 0));
        strobe(K_B, make_b(32'h0BADF00D));
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        jtag_op(K_A, make_a(1, 8'h10, 1, 0));
        chk("jwr_abort_ram", MonDReg, 32'hDEADBEEF);

        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        cyc = 0; free_at = 0; rd_edge = -1; wr_edge = -1;
        m_addr = '0; m_mond = '0; m_mond_known = 1'b1; m_ready = 1'b0; m_err = 1'b0; m_issued = 1'b0;
        m_rdval = '0; m_rd_known = 1'b0; m_cpu_val = '0; m_cpu_known = 1'b0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        op = 0;
        for (int n = 0; n < 3000; n++) begin
            act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin
                        act_a = 1'b1;
                        jdo = make_a($urandom_range(0, 1) == 1, pick_addr(),
                                     $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
                    end
                    1: begin
                        noact_a = 1'b1;
                        jdo = 38'($urandom);
                    end
                    default: begin
                        act_b = 1'b1;
                        jdo = make_b($urandom);
                    end
                endcase
            end
            if (op == 0) begin
                op = int'($urandom_range(0, 3));
                cpu_address    = pick_addr();
                cpu_writedata  = $urandom;
                cpu_byteenable = 4'($urandom_range(0, 15));
            end
            cpu_read  = (op == 1) || (op == 3);
            cpu_write = (op == 2) || (op == 3);
            model_cycle(ew);
            if (!ew) op = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
